// File: rtl/vmul_issue_ctrl.sv
// Multiply-path issue sequencer: streams operand beats into the multiplier under downstream credit control.
// Optional VMUL_ISSUE_PERF_EN adds busy/stall performance counters as extra outputs.
module vmul_issue_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int OPSEL_WIDTH = 2,
  parameter int SEW_WIDTH   = 2,
  parameter int BEAT_WIDTH  = 8,
  parameter int LATENCY     = 4,
  parameter int CREDITS     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [BEAT_WIDTH-1:0]  req_beats_i,
  input  logic [SEW_WIDTH-1:0]   req_sew_i,
  input  logic [OPSEL_WIDTH-1:0] req_opsel_i,
  input  logic                   opnd_valid_i,
  output logic                   opnd_ready_o,
  input  logic [DATA_WIDTH-1:0]  opnd_vec0_i,
  input  logic [DATA_WIDTH-1:0]  opnd_vec1_i,
  output logic                   dp_valid_o,
  output logic [DATA_WIDTH-1:0]  dp_vec0_o,
  output logic [DATA_WIDTH-1:0]  dp_vec1_o,
  output logic [SEW_WIDTH-1:0]   dp_sew_o,
  output logic [OPSEL_WIDTH-1:0] dp_opsel_o,
  output logic                   tag_valid_o,
  output logic                   tag_last_o,
  input  logic                   credit_ret_i,
  output logic                   busy_o
`ifdef VMUL_ISSUE_PERF_EN
  ,
  output logic [31:0]            perf_busy_cycles_o,
  output logic [31:0]            perf_stall_cycles_o
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic [BEAT_WIDTH-1:0]  beat_q;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic [CW-1:0]          credit_q;
  logic [CW-1:0]          credit_d;

  logic                   dp_valid_q;
  logic                   dp_last_q;
  logic [DATA_WIDTH-1:0]  dp_vec0_q;
  logic [DATA_WIDTH-1:0]  dp_vec1_q;
  logic [SEW_WIDTH-1:0]   dp_sew_q;
  logic [OPSEL_WIDTH-1:0] dp_opsel_q;
  logic [LATENCY-1:0]     tag_v_q;
  logic [LATENCY-1:0]     tag_l_q;
  logic [LATENCY:0]       v_chain;
  logic [LATENCY:0]       l_chain;

  logic issue;
  logic last_beat;
  logic pipe_empty;

  assign opnd_ready_o = (state_q == ISSUE) && (credit_q != '0);
  assign issue        = opnd_valid_i && opnd_ready_o;
  assign last_beat    = (beat_q == BEAT_WIDTH'(1));
  assign pipe_empty   = !dp_valid_q && !(|tag_v_q);
  // Ready is forced low while reset is held even though the state already reads IDLE.
  assign req_ready_o  = rst_ni && (state_q == IDLE);
  assign busy_o       = busy_q;

  assign dp_valid_o   = dp_valid_q;
  assign dp_vec0_o    = dp_vec0_q;
  assign dp_vec1_o    = dp_vec1_q;
  assign dp_sew_o     = dp_sew_q;
  assign dp_opsel_o   = dp_opsel_q;
  assign tag_valid_o  = tag_v_q[LATENCY-1];
  assign tag_last_o   = tag_l_q[LATENCY-1];

  assign v_chain = {tag_v_q, dp_valid_q};
  assign l_chain = {tag_l_q, dp_last_q};

  always_comb begin
    credit_d = credit_q;
    if (issue && !credit_ret_i) begin
      credit_d = credit_q - CW'(1);
    end else if (credit_ret_i && !issue && (credit_q != CW'(CREDITS))) begin
      credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      sew_q   <= '0;
      opsel_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            beat_q  <= (req_beats_i == '0) ? BEAT_WIDTH'(1) : req_beats_i;
            sew_q   <= req_sew_i;
            opsel_q <= req_opsel_i;
            state_q <= ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            beat_q <= beat_q - BEAT_WIDTH'(1);
            if (last_beat) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Idle cycles push empty tags, so the pipe head lines up with the multiplier output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_valid_q <= 1'b0;
      dp_last_q  <= 1'b0;
      dp_vec0_q  <= '0;
      dp_vec1_q  <= '0;
      dp_sew_q   <= '0;
      dp_opsel_q <= '0;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
      credit_q   <= CW'(CREDITS);
    end else begin
      dp_valid_q <= issue;
      dp_last_q  <= issue && last_beat;
      if (issue) begin
        dp_vec0_q  <= opnd_vec0_i;
        dp_vec1_q  <= opnd_vec1_i;
        dp_sew_q   <= sew_q;
        dp_opsel_q <= opsel_q;
      end
      tag_v_q  <= v_chain[LATENCY-1:0];
      tag_l_q  <= l_chain[LATENCY-1:0];
      credit_q <= credit_d;
    end
  end

`ifdef VMUL_ISSUE_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_stall_cycles_o = perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if ((state_q == ISSUE) && opnd_valid_i && (credit_q == '0)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Bench for vmul_issue_ctrl: directed and randomized commands checked against a
// schedule-based model (expected tag times, credit count, command phase).
module tb_vmul_issue_ctrl;

  localparam int LAT  = 4;
  localparam int CRED = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [7:0]  reqBeats = '0;
  logic [1:0]  reqSew = '0;
  logic [1:0]  reqOpsel = '0;
  logic        opndValid = 1'b0;
  logic        opndReady;
  logic [63:0] opndVec0 = '0;
  logic [63:0] opndVec1 = '0;
  logic        dpValid;
  logic [63:0] dpVec0;
  logic [63:0] dpVec1;
  logic [1:0]  dpSew;
  logic [1:0]  dpOpsel;
  logic        tagValid;
  logic        tagLast;
  logic        creditRet = 1'b0;
  logic        busy;
`ifdef VMUL_ISSUE_PERF_EN
  logic [31:0] perfBusy;
  logic [31:0] perfStall;
`endif

  vmul_issue_ctrl #(
    .DATA_WIDTH(64), .OPSEL_WIDTH(2), .SEW_WIDTH(2), .BEAT_WIDTH(8),
    .LATENCY(LAT), .CREDITS(CRED)
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_beats_i(reqBeats),
    .req_sew_i(reqSew), .req_opsel_i(reqOpsel),
    .opnd_valid_i(opndValid), .opnd_ready_o(opndReady),
    .opnd_vec0_i(opndVec0), .opnd_vec1_i(opndVec1),
    .dp_valid_o(dpValid), .dp_vec0_o(dpVec0), .dp_vec1_o(dpVec1),
    .dp_sew_o(dpSew), .dp_opsel_o(dpOpsel),
    .tag_valid_o(tagValid), .tag_last_o(tagLast),
    .credit_ret_i(creditRet), .busy_o(busy)
`ifdef VMUL_ISSUE_PERF_EN
    , .perf_busy_cycles_o(perfBusy), .perf_stall_cycles_o(perfStall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: command phase (0 idle, 1 issuing, 2 draining), beats remaining, credits,
  // and the absolute clock edge at which each tag must appear.
  int          edgeNum = 0;
  int          mode = 0;
  int          beatsLeft = 0;
  int          credits = CRED;
  int          idleEdge = -1;
  int          hsCount = 0;
  logic [1:0]  mSew = '0;
  logic [1:0]  mOpsel = '0;
  logic        expDpValid = 1'b0;
  logic [63:0] expV0 = '0;
  logic [63:0] expV1 = '0;
  logic [1:0]  expSew = '0;
  logic [1:0]  expOpsel = '0;
  bit [1:0]    tagExp [int];

  int   obsDp = 0;
  int   obsHs [$];
  int   obsLast [$];
  logic obsTags [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (edge %0d)", tag, obs, exp, edgeNum);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req_ready", reqReady, 1'b0);
    checkOutput("rst_opnd_ready", opndReady, 1'b0);
    checkOutput("rst_dp_valid", dpValid, 1'b0);
    checkOutput("rst_dp_vec0", dpVec0, 64'd0);
    checkOutput("rst_dp_vec1", dpVec1, 64'd0);
    checkOutput("rst_dp_sew", dpSew, 2'd0);
    checkOutput("rst_dp_opsel", dpOpsel, 2'd0);
    checkOutput("rst_tag_valid", tagValid, 1'b0);
    checkOutput("rst_tag_last", tagLast, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
  endtask

  task automatic modelReset();
    mode = 0; beatsLeft = 0; credits = CRED; idleEdge = -1;
    mSew = '0; mOpsel = '0; expDpValid = 1'b0;
    expV0 = '0; expV1 = '0; expSew = '0; expOpsel = '0;
    tagExp.delete();
  endtask

  // Reset asserted between clock edges so the asynchronous clear is observed immediately.
  task automatic doReset(input int holdCycles);
    @(negedge clk);
    reqValid = 1'b0; opndValid = 1'b0; creditRet = 1'b0;
    #2 rstN = 1'b0;
    #1 checkResetValues();
    modelReset();
    repeat (holdCycles) begin
      @(posedge clk);
      edgeNum++;
    end
    #1 checkResetValues();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic applyStimulus(input logic rv, input logic [7:0] beats, input logic [1:0] sew,
                               input logic [1:0] opsel, input logic ov, input logic [63:0] v0,
                               input logic [63:0] v1, input logic cr);
    logic expReq, expOpnd, hs, iss, lst;
    bit [1:0] et;
    @(negedge clk);
    reqValid = rv; reqBeats = beats; reqSew = sew; reqOpsel = opsel;
    opndValid = ov; opndVec0 = v0; opndVec1 = v1; creditRet = cr;
    #1;
    expReq  = (mode == 0);
    expOpnd = (mode == 1) && (credits > 0);
    checkOutput("req_ready", reqReady, expReq);
    checkOutput("opnd_ready", opndReady, expOpnd);
    checkOutput("busy", busy, mode != 0);
    if (rv && reqReady) obsHs.push_back(edgeNum + 1);
    hs  = rv && expReq;
    iss = ov && expOpnd;
    @(posedge clk);
    edgeNum++;
    lst = 1'b0;
    if (iss) begin
      beatsLeft--;
      lst = (beatsLeft == 0);
      expV0 = v0; expV1 = v1; expSew = mSew; expOpsel = mOpsel;
      tagExp[edgeNum + LAT] = {1'b1, lst};
      if (lst) begin
        mode = 2;
        idleEdge = edgeNum + LAT + 2;
      end
    end
    expDpValid = iss;
    if (iss && !cr) credits--;
    else if (cr && !iss && credits < CRED) credits++;
    if (hs) begin
      mode = 1;
      hsCount++;
      beatsLeft = (beats == 0) ? 1 : int'(beats);
      mSew = sew; mOpsel = opsel;
    end else if (mode == 2 && edgeNum == idleEdge) begin
      mode = 0;
    end
    et = tagExp.exists(edgeNum) ? tagExp[edgeNum] : 2'b00;
    if (tagExp.exists(edgeNum)) tagExp.delete(edgeNum);
    #1;
    checkOutput("dp_valid", dpValid, expDpValid);
    checkOutput("dp_vec0", dpVec0, expV0);
    checkOutput("dp_vec1", dpVec1, expV1);
    checkOutput("dp_sew", dpSew, expSew);
    checkOutput("dp_opsel", dpOpsel, expOpsel);
    checkOutput("tag_valid", tagValid, et[1]);
    checkOutput("tag_last", tagLast, et[0]);
    if (dpValid) obsDp++;
    if (tagValid) obsTags.push_back(tagLast);
    if (tagLast) obsLast.push_back(edgeNum);
  endtask

  task automatic drainToIdle(input logic cr);
    int n = 0;
    while (mode != 0 && n < 60) begin
      applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b0, 64'd0, 64'd0, cr);
      n++;
    end
    repeat (CRED + 1) applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b1);
  endtask

  task automatic clearObs();
    obsDp = 0; obsHs.delete(); obsLast.delete(); obsTags.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeNum);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] r0, r1;
    int n;
    // Power-on reset
    rstN = 1'b0;
    #1 checkResetValues();
    repeat (2) begin
      @(posedge clk);
      edgeNum++;
    end
    #1 checkResetValues();
    @(negedge clk);
    rstN = 1'b1;

    // Single beat, fixed operands
    clearObs();
    r1 = {$urandom, $urandom};
    applyStimulus(1'b1, 8'd1, 2'b10, 2'b11, 1'b0, 64'd0, 64'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 64'hFFFF_FFFF_0000_0002, r1, 1'b0);
    drainToIdle(1'b0);
    checkOutput("single_dp_pulses", obsDp, 1);
    checkOutput("single_tag_count", obsTags.size(), 1);
    checkOutput("single_tag_last", obsLast.size(), 1);

    // Zero beats behaves as one
    clearObs();
    applyStimulus(1'b1, 8'd0, 2'b01, 2'b10, 1'b1, 64'd0, 64'd0, 1'b0);
    n = 0;
    while (mode == 1 && n < 10) begin
      applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      n++;
    end
    drainToIdle(1'b0);
    checkOutput("zero_dp_pulses", obsDp, 1);
    checkOutput("zero_tag_count", obsTags.size(), 1);
    checkOutput("zero_tag_last", obsLast.size(), 1);

    // Credit stall, then issue and credit return in the same cycle at one credit
    clearObs();
    applyStimulus(1'b1, 8'd6, 2'b11, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (6) applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    checkOutput("stall_issued", obsDp, CRED);
    applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    checkOutput("stall_after_ret", obsDp, CRED);
    applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    checkOutput("stall_all_issued", obsDp, 6);
    drainToIdle(1'b1);
    checkOutput("stall_tag_count", obsTags.size(), 6);
    checkOutput("stall_tag_last", obsLast.size(), 1);

    // Randomized commands with random valid and credit traffic
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 1'b0, 64'd0, 64'd0, 1'b0);
      n = 0;
      while (mode == 1 && n < 200) begin
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};
        applyStimulus(1'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                      1'($urandom), r0, r1, 1'($urandom));
        n++;
      end
      drainToIdle(1'($urandom));
    end

    // Reset in the middle of an 8-beat command
    applyStimulus(1'b1, 8'd8, 2'b10, 2'b00, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    doReset(2);
    clearObs();
    applyStimulus(1'b1, 8'd2, 2'b01, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'd0, 2'd0, 2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    drainToIdle(1'b1);
    checkOutput("post_rst_tag_count", obsTags.size(), 2);
    checkOutput("post_rst_first_last", obsTags[0], 1'b0);
    checkOutput("post_rst_second_last", obsTags[1], 1'b1);

    // Back-to-back 3-beat commands with request held high
    clearObs();
    hsCount = 0;
    n = 0;
    while ((hsCount < 2 || mode != 0) && n < 100) begin
      applyStimulus(hsCount < 2, 8'd3, 2'($urandom), 2'($urandom), 1'b1,
                    {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      n++;
    end
    drainToIdle(1'b1);
    checkOutput("b2b_handshakes", obsHs.size(), 2);
    checkOutput("b2b_tag_last_count", obsLast.size(), 2);
    checkOutput("b2b_gap_ok", (obsHs.size() == 2 && obsLast.size() >= 1 && obsHs[1] - obsLast[0] >= 2), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
